// File: rtl/wave_uart_packer_if.sv
// Byte-stream and buffer-read bundle between the packer and its neighbours.
// master = packer side: drives rd_addr and tx byte, samples rd_data and tx_ready.
interface wave_uart_packer_if #(
    parameter int SAMPLE_W = 14,
    parameter int ADDR_W   = 10
);
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (
        output rd_addr,
        input  rd_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/wave_uart_packer.sv
// Frames one acquisition as AA 55 wn_hi wn_lo {s_hi s_lo}*N xor_cksum onto a byte stream.
// Latency: first byte valid 1 cycle after start; 4 cycles per sample at full rate.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; start ignored while busy.
module wave_uart_packer #(
    parameter int N_SAMPLES = 1000,
    parameter int SAMPLE_W  = 14,
    parameter int ADDR_W    = 10
) (
    input  logic                clk_50,
    input  logic                reset_n,
    input  logic                start,
    input  logic [15:0]         wave_number,
    wave_uart_packer_if.master  bus,
    output logic                busy,
    output logic                done
);

    typedef enum logic [3:0] {
        IDLE, SYNC0, SYNC1, WN_HI, WN_LO, FETCH, LATCH, S_HI, S_LO, CKSUM, FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_SAMPLES - 1);

    state_t            state;
    logic [15:0]       wn_q;
    logic [7:0]        cksum;
    logic [7:0]        sample_lo;
    logic [ADDR_W-1:0] k;
    logic              accept;
    logic [15:0]       rd_ext;

    assign accept = bus.tx_valid && bus.tx_ready;
    assign rd_ext = 16'(bus.rd_data);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wn_q         <= '0;
            cksum        <= '0;
            sample_lo    <= '0;
            k            <= '0;
            bus.rd_addr  <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wn_q         <= wave_number;
                        cksum        <= '0;
                        k            <= '0;
                        busy         <= 1'b1;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= 8'hAA;
                        state        <= SYNC0;
                    end
                end
                SYNC0: begin
                    if (accept) begin
                        bus.tx_data <= 8'h55;
                        state       <= SYNC1;
                    end
                end
                SYNC1: begin
                    if (accept) begin
                        bus.tx_data <= wn_q[15:8];
                        state       <= WN_HI;
                    end
                end
                WN_HI: begin
                    if (accept) begin
                        cksum       <= cksum ^ bus.tx_data;
                        bus.tx_data <= wn_q[7:0];
                        state       <= WN_LO;
                    end
                end
                WN_LO: begin
                    if (accept) begin
                        cksum        <= cksum ^ bus.tx_data;
                        bus.tx_valid <= 1'b0;
                        bus.rd_addr  <= k;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    // Buffer data for rd_addr is valid now; high byte goes out directly.
                    sample_lo    <= rd_ext[7:0];
                    bus.tx_data  <= rd_ext[15:8];
                    bus.tx_valid <= 1'b1;
                    state        <= S_HI;
                end
                S_HI: begin
                    if (accept) begin
                        cksum       <= cksum ^ bus.tx_data;
                        bus.tx_data <= sample_lo;
                        state       <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        cksum <= cksum ^ bus.tx_data;
                        if (k == LAST_K) begin
                            bus.tx_data <= cksum ^ bus.tx_data;
                            state       <= CKSUM;
                        end else begin
                            k            <= k + ADDR_W'(1);
                            bus.rd_addr  <= k + ADDR_W'(1);
                            bus.tx_valid <= 1'b0;
                            state        <= FETCH;
                        end
                    end
                end
                CKSUM: begin
                    if (accept) begin
                        bus.tx_valid <= 1'b0;
                        done         <= 1'b1;
                        state        <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_uart_packer.sv
// Scoreboarded bench: a 2-sample instance for directed framing, a default instance for full packets.
module tb_wave_uart_packer;

    logic clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    logic        rst_s_n, rst_b_n, start_s, start_b;
    logic [15:0] wn_s, wn_b;
    logic        busy_s, done_s, busy_b, done_b;
    logic        bp_b;

    wave_uart_packer_if #(.SAMPLE_W(14), .ADDR_W(1))  bus_s ();
    wave_uart_packer_if #(.SAMPLE_W(14), .ADDR_W(10)) bus_b ();

    wave_uart_packer #(.N_SAMPLES(2), .SAMPLE_W(14), .ADDR_W(1)) u_small (
        .clk_50(clk_50), .reset_n(rst_s_n), .start(start_s), .wave_number(wn_s),
        .bus(bus_s), .busy(busy_s), .done(done_s)
    );

    wave_uart_packer #(.N_SAMPLES(1000), .SAMPLE_W(14), .ADDR_W(10)) u_big (
        .clk_50(clk_50), .reset_n(rst_b_n), .start(start_b), .wave_number(wn_b),
        .bus(bus_b), .busy(busy_b), .done(done_b)
    );

    // Synchronous-read sample buffers; the big one holds sample[k] = k.
    logic [13:0] mem_s [0:1];
    always @(posedge clk_50) bus_s.rd_data <= mem_s[bus_s.rd_addr];
    always @(posedge clk_50) bus_b.rd_data <= 14'(bus_b.rd_addr);

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    initial begin
        bus_s.tx_ready = 1'b1;
        bus_b.tx_ready = 1'b1;
        forever begin
            @(posedge clk_50);
            #1;
            bus_b.tx_ready = bp_b ? (($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0) : 1'b1;
        end
    end

    logic [7:0] exp_s[$];
    logic [7:0] exp_b[$];
    int checks = 0;
    int errors = 0;
    int ndone_s = 0, ndone_b = 0;
    int start_cyc_s = 0, start_cyc_b = 0;
    bit tim_s = 1'b1, tim_b = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Monitors: pop expected bytes on each accepted transfer, check hold and done/busy timing.
    logic [7:0] pd_s, pd_b;
    logic       pv_s = 0, pr_s = 0, pdone_s = 0, pv_b = 0, pr_b = 0, pdone_b = 0;

    always @(negedge clk_50) begin
        if (!rst_s_n) begin
            pv_s = 1'b0;
            pdone_s = 1'b0;
        end else begin
            if (pv_s && !pr_s) begin
                chk("s_hold_valid", int'(bus_s.tx_valid), 1);
                chk("s_hold_data", int'(bus_s.tx_data), int'(pd_s));
            end
            if (bus_s.tx_valid && bus_s.tx_ready) begin
                if (exp_s.size() == 0) fail_now("s_extra_byte", int'(bus_s.tx_data));
                else chk("s_byte", int'(bus_s.tx_data), int'(exp_s.pop_front()));
            end
            if (done_s) begin
                ndone_s++;
                chk("s_busy_with_done", int'(busy_s), 1);
                if (tim_s) chk("s_done_latency", cyc - start_cyc_s, 5 + 4 * 2);
                chk("s_queue_drained", exp_s.size(), 0);
            end
            if (pdone_s) chk("s_busy_after_done", int'(busy_s), 0);
            pv_s = bus_s.tx_valid;
            pr_s = bus_s.tx_ready;
            pd_s = bus_s.tx_data;
            pdone_s = done_s;
        end
    end

    always @(negedge clk_50) begin
        if (!rst_b_n) begin
            pv_b = 1'b0;
            pdone_b = 1'b0;
        end else begin
            if (pv_b && !pr_b) begin
                chk("b_hold_valid", int'(bus_b.tx_valid), 1);
                chk("b_hold_data", int'(bus_b.tx_data), int'(pd_b));
            end
            if (bus_b.tx_valid && bus_b.tx_ready) begin
                if (exp_b.size() == 0) fail_now("b_extra_byte", int'(bus_b.tx_data));
                else chk("b_byte", int'(bus_b.tx_data), int'(exp_b.pop_front()));
            end
            if (done_b) begin
                ndone_b++;
                chk("b_busy_with_done", int'(busy_b), 1);
                if (tim_b) chk("b_done_latency", cyc - start_cyc_b, 5 + 4 * 1000);
                chk("b_queue_drained", exp_b.size(), 0);
            end
            if (pdone_b) chk("b_busy_after_done", int'(busy_b), 0);
            pv_b = bus_b.tx_valid;
            pr_b = bus_b.tx_ready;
            pd_b = bus_b.tx_data;
            pdone_b = done_b;
        end
    end

    task automatic push_s(input logic [7:0] b [9]);
        foreach (b[i]) exp_s.push_back(b[i]);
    endtask

    // Reference packet for the default instance: sample[k] = k.
    task automatic push_model_b(input logic [15:0] wn);
        logic [7:0]  cs;
        logic [15:0] s;
        exp_b.push_back(8'hAA);
        exp_b.push_back(8'h55);
        exp_b.push_back(wn[15:8]);
        exp_b.push_back(wn[7:0]);
        cs = wn[15:8] ^ wn[7:0];
        for (int k = 0; k < 1000; k++) begin
            s = 16'(k);
            exp_b.push_back(s[15:8]);
            exp_b.push_back(s[7:0]);
            cs = cs ^ s[15:8] ^ s[7:0];
        end
        exp_b.push_back(cs);
    endtask

    task automatic start_s_pkt(input logic [15:0] wn);
        @(posedge clk_50);
        #1;
        wn_s = wn;
        start_s = 1'b1;
        @(posedge clk_50);
        #1;
        start_s = 1'b0;
        start_cyc_s = cyc;
        chk("s_busy_rise", int'(busy_s), 1);
        chk("s_first_valid", int'(bus_s.tx_valid), 1);
    endtask

    task automatic start_b_pkt(input logic [15:0] wn);
        @(posedge clk_50);
        #1;
        wn_b = wn;
        start_b = 1'b1;
        @(posedge clk_50);
        #1;
        start_b = 1'b0;
        start_cyc_b = cyc;
        chk("b_busy_rise", int'(busy_b), 1);
    endtask

    task automatic wait_done_s(input int target, input int budget);
        int n = 0;
        while (ndone_s < target && n < budget) begin
            @(posedge clk_50);
            n++;
        end
        if (ndone_s < target) fail_now("s_done_timeout", ndone_s);
    endtask

    task automatic wait_done_b(input int target, input int budget);
        int n = 0;
        while (ndone_b < target && n < budget) begin
            @(posedge clk_50);
            n++;
        end
        if (ndone_b < target) fail_now("b_done_timeout", ndone_b);
    endtask

    initial begin
        logic [7:0] pk1 [9] = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h12, 8'h34, 8'h0A, 8'hBC, 8'h93};
        logic [7:0] pk2 [9] = '{8'hAA, 8'h55, 8'hFF, 8'hEE, 8'h3F, 8'hFF, 8'h00, 8'h01, 8'hD0};
        logic [7:0] pk3 [9] = '{8'hAA, 8'h55, 8'h03, 8'h04, 8'h12, 8'h34, 8'h0A, 8'hBC, 8'h97};
        int n;
        rst_s_n = 1'b0; rst_b_n = 1'b0;
        start_s = 1'b0; start_b = 1'b0;
        wn_s = '0; wn_b = '0; bp_b = 1'b0;
        mem_s[0] = 14'h1234; mem_s[1] = 14'h0ABC;
        repeat (3) @(posedge clk_50);
        #1;
        chk("s_rst_valid", int'(bus_s.tx_valid), 0);
        chk("s_rst_data", int'(bus_s.tx_data), 0);
        chk("s_rst_addr", int'(bus_s.rd_addr), 0);
        chk("s_rst_busy", int'(busy_s), 0);
        chk("s_rst_done", int'(done_s), 0);
        chk("b_rst_valid", int'(bus_b.tx_valid), 0);
        chk("b_rst_data", int'(bus_b.tx_data), 0);
        chk("b_rst_addr", int'(bus_b.rd_addr), 0);
        chk("b_rst_busy", int'(busy_b), 0);
        chk("b_rst_done", int'(done_b), 0);
        rst_s_n = 1'b1; rst_b_n = 1'b1;

        // Basic framing and checksum.
        push_s(pk1);
        start_s_pkt(16'h0102);
        wait_done_s(1, 100);

        // Max-value sample.
        mem_s[0] = 14'h3FFF; mem_s[1] = 14'h0001;
        push_s(pk2);
        start_s_pkt(16'hFFEE);
        wait_done_s(2, 100);

        // Start while busy (header and FIN), wave_number changed mid-packet.
        mem_s[0] = 14'h1234; mem_s[1] = 14'h0ABC;
        push_s(pk1);
        start_s_pkt(16'h0102);
        repeat (2) @(posedge clk_50);
        #1;
        wn_s = 16'hFFFF;
        start_s = 1'b1;
        @(posedge clk_50);
        #1;
        start_s = 1'b0;
        n = 0;
        while (!done_s && n < 100) begin
            @(posedge clk_50);
            #1;
            n++;
        end
        if (!done_s) fail_now("s_fin_timeout", n);
        wn_s = 16'h0304;
        start_s = 1'b1;
        @(posedge clk_50);
        #1;
        chk("s_fin_start_ignored", int'(busy_s), 0);
        push_s(pk3);
        @(posedge clk_50);
        #1;
        start_s = 1'b0;
        start_cyc_s = cyc;
        chk("s_idle_start_taken", int'(busy_s), 1);
        wait_done_s(4, 100);
        repeat (30) @(posedge clk_50);
        #1;
        chk("s_idle_after", int'(busy_s), 0);

        // Full default packet at full rate.
        push_model_b(16'hBEEF);
        start_b_pkt(16'hBEEF);
        wait_done_b(1, 4100);

        // Backpressure: same stream, arbitrary timing.
        tim_b = 1'b0;
        bp_b = 1'b1;
        push_model_b(16'h1357);
        start_b_pkt(16'h1357);
        wait_done_b(2, 20000);
        bp_b = 1'b0;
        tim_b = 1'b1;

        // Reset during S_LO of sample 500, then a fresh packet.
        push_model_b(16'h2468);
        start_b_pkt(16'h2468);
        n = 0;
        while (!(bus_b.rd_addr == 10'd500 && bus_b.tx_valid && bus_b.tx_data == 8'hF4) && n < 3000) begin
            @(posedge clk_50);
            #1;
            n++;
        end
        if (n >= 3000) fail_now("b_s_lo_500_timeout", n);
        rst_b_n = 1'b0;
        #1;
        chk("b_mid_rst_valid", int'(bus_b.tx_valid), 0);
        chk("b_mid_rst_data", int'(bus_b.tx_data), 0);
        chk("b_mid_rst_addr", int'(bus_b.rd_addr), 0);
        chk("b_mid_rst_busy", int'(busy_b), 0);
        chk("b_mid_rst_done", int'(done_b), 0);
        exp_b.delete();
        repeat (2) @(posedge clk_50);
        #1;
        rst_b_n = 1'b1;
        push_model_b(16'h0A0B);
        start_b_pkt(16'h0A0B);
        wait_done_b(3, 4100);
        repeat (10) @(posedge clk_50);

        chk("s_done_count", ndone_s, 4);
        chk("b_done_count", ndone_b, 3);
        chk("b_queue_final", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
